// File: rtl/spi_sys_arbiter_if.sv
// spi_sys_arbiter_if: requester handshakes and system register bus shared by spi_sys_arbiter
// master: arbiter side (takes requests, drives ready/rvalid/rdata, sys strobes/addr/wdata, busy)
// slave: requesters and register bus side (drives requests and sys_rdata)
interface spi_sys_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
);
  logic              req0_valid, req0_wr, req0_lock, req0_ready, req0_rvalid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata, req0_rdata;
  logic              req1_valid, req1_wr, req1_lock, req1_ready, req1_rvalid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata, req1_rdata;
  logic              sys_wr_en, sys_rd_en, busy;
  logic [ADDR_W-1:0] sys_addr;
  logic [DATA_W-1:0] sys_wdata, sys_rdata;
  modport master (
    input  req0_valid, req0_wr, req0_lock, req0_addr, req0_wdata,
    input  req1_valid, req1_wr, req1_lock, req1_addr, req1_wdata,
    input  sys_rdata,
    output req0_ready, req0_rvalid, req0_rdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output sys_wr_en, sys_rd_en, sys_addr, sys_wdata, busy
  );
  modport slave (
    output req0_valid, req0_wr, req0_lock, req0_addr, req0_wdata,
    output req1_valid, req1_wr, req1_lock, req1_addr, req1_wdata,
    output sys_rdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  sys_wr_en, sys_rd_en, sys_addr, sys_wdata, busy
  );
endinterface

// File: rtl/spi_sys_arbiter.sv
// spi_sys_arbiter: round-robin two-requester arbiter for the single-beat system register bus
// sys_clk/sys_rst: clock and asynchronous active-high reset; bus: spi_sys_arbiter_if.master
// Optional SPI_ARB_LOCK_EN: a requester issuing with lock=1 keeps exclusive grant until it issues with lock=0
module spi_sys_arbiter #(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 16
) (
  input logic               sys_clk,
  input logic               sys_rst,
  spi_sys_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic              id_q, id_d, wr_q, wr_d, ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              elig0, elig1, win;
`ifdef SPI_ARB_LOCK_EN
  logic              lock_q, lock_d, own_v_q, own_v_d, own_q, own_d;
  assign elig0 = bus.req0_valid && !(own_v_q && own_q);
  assign elig1 = bus.req1_valid && !(own_v_q && !own_q);
`else
  logic              unused_lock;
  assign unused_lock = bus.req0_lock ^ bus.req1_lock;
  assign elig0 = bus.req0_valid;
  assign elig1 = bus.req1_valid;
`endif
  // ptr_q holds the last granted id, so contention goes to the other one
  assign win = (elig0 && elig1) ? !ptr_q : elig1;
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    wr_d     = wr_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef SPI_ARB_LOCK_EN
    lock_d   = lock_q;
    own_v_d  = own_v_q;
    own_d    = own_q;
`endif
    case (state_q)
      IDLE: if (elig0 || elig1) begin
        state_d = ISSUE;
        id_d    = win;
        ptr_d   = win;
        wr_d    = win ? bus.req1_wr : bus.req0_wr;
        addr_d  = win ? bus.req1_addr : bus.req0_addr;
        wdata_d = win ? bus.req1_wdata : bus.req0_wdata;
`ifdef SPI_ARB_LOCK_EN
        lock_d  = win ? bus.req1_lock : bus.req0_lock;
`endif
      end
      ISSUE: begin
        state_d = wr_q ? IDLE : RDWAIT;
        cnt_d   = '0;
`ifdef SPI_ARB_LOCK_EN
        if (lock_q) begin
          own_v_d = 1'b1;
          own_d   = id_q;
        end else if (own_v_q && own_q == id_q) begin
          own_v_d = 1'b0;
        end
`endif
      end
      RDWAIT: begin
        cnt_d = cnt_q + 4'd1;
        // cnt_q counts RDWAIT cycles already spent; the last one ends RD_LATENCY cycles after ISSUE
        if (cnt_q == 4'(RD_LATENCY - 1)) begin
          state_d  = RESP;
          rdata0_d = id_q ? rdata0_q : bus.sys_rdata;
          rdata1_d = id_q ? bus.sys_rdata : rdata1_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      id_q     <= 1'b0;
      wr_q     <= 1'b0;
      ptr_q    <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef SPI_ARB_LOCK_EN
      lock_q   <= 1'b0;
      own_v_q  <= 1'b0;
      own_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      wr_q     <= wr_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef SPI_ARB_LOCK_EN
      lock_q   <= lock_d;
      own_v_q  <= own_v_d;
      own_q    <= own_d;
`endif
    end
  end
  assign bus.req0_ready  = state_q == ISSUE && !id_q;
  assign bus.req1_ready  = state_q == ISSUE && id_q;
  assign bus.req0_rvalid = state_q == RESP && !id_q;
  assign bus.req1_rvalid = state_q == RESP && id_q;
  assign bus.sys_wr_en   = state_q == ISSUE && wr_q;
  assign bus.sys_rd_en   = state_q == ISSUE && !wr_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.sys_addr    = addr_q;
  assign bus.sys_wdata   = wdata_q;
  assign bus.req0_rdata  = rdata0_q;
  assign bus.req1_rdata  = rdata1_q;
endmodule

// File: doc/spi_sys_arbiter.md
# spi_sys_arbiter

Two-port arbiter sharing the internal 15-bit-address / 16-bit-data system register bus (sys_wr_en, sys_rd_en, sys_addr, sys_wdata, sys_rdata) that feeds the FPGA register file and SPI master blocks. Requester 0 is the host SPI slave; requester 1 is a local autonomous agent (init sequencer or monitor). The block serialises single-beat register transactions with round-robin fairness, tracks fixed read latency, and returns read data to the owning requester. An optional lock lets one requester own the bus for an atomic burst.

## Interface
- RD_LATENCY, 2, cycles from the sys_rd_en pulse to the sys_clk edge at which sys_rdata is valid; legal 1..15.
- ADDR_W, 15, address width.
- DATA_W, 16, data width.

- sys_clk  in  1  single clock; all logic on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- reqN_valid  in  1  (N = 0, 1) transaction request; held stable with fields until reqN_ready.
- reqN_wr  in  1  1 = write, 0 = read.
- reqN_addr  in  ADDR_W  register address.
- reqN_wdata  in  DATA_W  write data.
- reqN_lock  in  1  keep grant after this transaction (see Configuration).
- reqN_ready  out  1  one-cycle accept pulse.
- reqN_rvalid  out  1  one-cycle read-data-valid pulse.
- reqN_rdata  out  DATA_W  read data, held until next read response to N.
- sys_wr_en  out  1  one-cycle write strobe.
- sys_rd_en  out  1  one-cycle read strobe.
- sys_addr  out  ADDR_W  registered address.
- sys_wdata  out  DATA_W  registered write data.
- sys_rdata  in  DATA_W  read data from decode pipeline.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, RDWAIT, RESP.
- IDLE: if any reqN_valid, pick winner, register its wr/addr/wdata/lock and winner id, go to ISSUE. Neither valid: stay.
- Round-robin: pointer names last granted requester; on contention the other requester wins. Single requester wins immediately. Pointer resets to 1 (requester 0 wins first contention).
- ISSUE (1 cycle): winner's reqN_ready = 1; sys_wr_en or sys_rd_en = 1 per registered wr; sys_addr/sys_wdata driven from registers. Write -> IDLE. Read -> RDWAIT with latency counter cleared.
- RDWAIT: counter increments each cycle; at the edge ending cycle ISSUE+RD_LATENCY, sys_rdata captured into winner's reqN_rdata and go to RESP.
- RESP (1 cycle): winner's reqN_rvalid = 1, then IDLE.
- reqN_valid dropped before accept: no transaction, no ready. Valid in non-IDLE states is ignored until IDLE.
- Only one of sys_wr_en/sys_rd_en ever high; both ready and both rvalid never high together.
- sys_addr/sys_wdata hold last value outside ISSUE.

## Timing
- Reset values: all strobes, ready, rvalid, busy = 0; sys_addr, sys_wdata, reqN_rdata = 0; state IDLE; pointer = 1; lock owner cleared.
- Request seen in IDLE at cycle T: ready + strobe at T+1.
- Write: 2 cycles per transaction; back-to-back writes from alternating requesters every 2 cycles.
- Read: strobe at T+1, sys_rdata sampled at end of T+1+RD_LATENCY, rvalid at T+2+RD_LATENCY; next grant decision earliest T+3+RD_LATENCY.
- Reset asserted mid-transaction: immediate return to reset values; in-flight read discarded, no rvalid issued.

## Configuration
- SPI_ARB_LOCK_EN defined: if winner's registered lock = 1 at ISSUE, the winner becomes lock owner; in IDLE only the owner may be granted, other requester stalls regardless of pointer. Owner's next accepted transaction with lock = 0 releases ownership at its ISSUE. Pointer still updates on each grant.
- Not defined: reqN_lock ports present but ignored; pure round-robin.

## Test plan
- Reset, req0 write addr 0x0103 data 0xA5A5 -> ready0 and sys_wr_en at T+1 with sys_addr 0x0103, sys_wdata 0xA5A5; busy 1 cycle.
- req1 read addr 0x0140, RD_LATENCY 2, sys_rdata 0x1234 driven at that edge -> sys_rd_en T+1, rvalid1 T+4 with rdata1 0x1234, rdata0 unchanged.
- Both valid continuously, writes -> grants alternate 0,1,0,1, one strobe every 2 cycles.
- SPI_ARB_LOCK_EN: req0 three writes lock=1,1,0 while req1 valid -> three req0 grants before req1; without macro -> alternation.
- sys_rst pulsed during RDWAIT -> no rvalid, all outputs 0, next contention granted to req0.
- req0 valid raised then dropped while read from req1 in progress -> no ready0, no strobe for req0.
